barrel_shifter_pipe: RTL and testbench



---
 rtl/barrel_pkg.sv | 9 +
 rtl/barrel_stage.sv | 74 +++++++
 rtl/barrel_shifter_pipe.sv | 67 ++++++
 tb/tb_barrel_shifter_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared types for the pipelined barrel shifter.
package barrel_pkg;
  typedef enum logic [1:0] {
    MODE_SLL = 2'd0,
    MODE_SRL = 2'd1,
    MODE_SRA = 2'd2,
    MODE_ROL = 2'd3
  } mode_t;
endpackage

// File: rtl/barrel_stage.sv
// One pipeline step: conditionally shifts by SHIFT, tracks the last bit shifted out.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             next_adv,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [SHW-1:0]   prev_sh,
  input  mode_t            prev_mode,
  input  logic             prev_carry,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   sh,
  output mode_t            mode,
  output logic             carry
);
  localparam int BIT = $clog2(SHIFT);

  logic             adv;
  logic [WIDTH-1:0] sh_data;
  logic             sh_carry;

  assign adv = !valid || next_adv;

  // Carry only changes when this stage actually shifts.
  always_comb begin
    sh_data  = prev_data;
    sh_carry = prev_carry;
    if (prev_sh[BIT]) begin
      case (prev_mode)
        MODE_SLL: begin
          sh_data  = prev_data << SHIFT;
          sh_carry = prev_data[WIDTH-SHIFT];
        end
        MODE_SRL: begin
          sh_data  = prev_data >> SHIFT;
          sh_carry = prev_data[SHIFT-1];
        end
        MODE_SRA: begin
          sh_data  = WIDTH'($signed(prev_data) >>> SHIFT);
          sh_carry = prev_data[SHIFT-1];
        end
        MODE_ROL: begin
          sh_data  = {prev_data[WIDTH-SHIFT-1:0], prev_data[WIDTH-1:WIDTH-SHIFT]};
          sh_carry = prev_data[WIDTH-SHIFT];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      sh    <= '0;
      mode  <= MODE_SLL;
      carry <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data  <= sh_data;
        sh    <= prev_sh;
        mode  <= prev_mode;
        carry <= sh_carry;
      end
    end
  end
endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, valid/ready on both ends.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int  WIDTH  = 8,
  localparam int SHW    = $clog2(WIDTH),
  localparam int STAGES = SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_sh,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] data_pipe;
  logic [STAGES:0][SHW-1:0]   sh_pipe;
  mode_t [STAGES:0]           mode_pipe;
  logic [STAGES:0]            carry_pipe;
  logic [STAGES-1:0]          next_adv;
  logic                       unused_tail;

  assign vld_pipe[0]   = in_valid;
  assign data_pipe[0]  = in_data;
  assign sh_pipe[0]    = in_sh;
  assign mode_pipe[0]  = mode_t'(in_mode);
  assign carry_pipe[0] = 1'b0;

  // A stage advances iff some stage at or after it is empty, or the output drains;
  // written in closed form so the ready chain has no self-referencing vector.
  assign in_ready  = rst_n && (out_ready || !(&vld_pipe[STAGES:1]));
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = data_pipe[STAGES];
  assign out_carry = carry_pipe[STAGES];

  assign unused_tail = ^{sh_pipe[STAGES], mode_pipe[STAGES]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STAGES - 1) begin : g_last
      assign next_adv[k] = out_ready;
    end else begin : g_mid
      assign next_adv[k] = out_ready || !(&vld_pipe[STAGES:k+2]);
    end

    barrel_stage #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .next_adv  (next_adv[k]),
      .prev_valid(vld_pipe[k]),
      .prev_data (data_pipe[k]),
      .prev_sh   (sh_pipe[k]),
      .prev_mode (mode_pipe[k]),
      .prev_carry(carry_pipe[k]),
      .valid     (vld_pipe[k+1]),
      .data      (data_pipe[k+1]),
      .sh        (sh_pipe[k+1]),
      .mode      (mode_pipe[k+1]),
      .carry     (carry_pipe[k+1])
    );
  end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at WIDTH = 8.
module tb_barrel_shifter_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_sh = '0;
  logic [1:0] in_mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_carry;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [8:0] exp_q[$];
  logic       held_v = 1'b0;
  logic [8:0] held_val = '0;

  barrel_shifter_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sh(in_sh), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: {carry, result}
  function automatic logic [8:0] ref_shift(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
    logic [7:0] r;
    logic       c;
    r = d;
    c = 1'b0;
    if (s != 0) begin
      case (m)
        2'd0: begin r = d << s; c = d[8-s]; end
        2'd1: begin r = d >> s; c = d[s-1]; end
        2'd2: begin r = $signed(d) >>> s; c = d[s-1]; end
        default: begin r = (d << s) | (d >> (8 - s)); c = d[8-s]; end
      endcase
    end
    return {c, r};
  endfunction

  // Output monitor: pops on every transfer, checks held outputs under stall.
  always @(negedge clk) begin
    if (!rst_n) held_v = 1'b0;
    else begin
      if (held_v) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_carry, out_data}), 32'(held_val));
      end
      if (out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
        else if (out_valid) check("result", 32'({out_carry, out_data}), 32'(exp_q.pop_front()));
      end
      held_v   = out_valid && !out_ready;
      held_val = {out_carry, out_data};
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m, input logic [8:0] e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_sh = s; in_mode = m;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
    if (acc) exp_q.push_back(e);
  endtask

  // Beat accepted at edge 1 must be visible right after edge 3, not after edge 2.
  task automatic lat_test(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m, input logic [8:0] e);
    send(d, s, m, e);
    @(posedge clk); #1;
    check("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_on", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic acc;
    int   idx;
    int   cnt;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out", 32'({out_carry, out_data}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("first_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    lat_test(8'hB5, 3'd3, 2'd0, 9'h1A8);
    drain();
    send(8'h96, 3'd2, 2'd1, 9'h125);
    send(8'h96, 3'd2, 2'd2, 9'h1E5);
    send(8'h96, 3'd3, 2'd3, 9'h0B4);
    for (int m = 0; m < 4; m++) send(8'h96, 3'd0, 2'(m), 9'h096);
    drain();

    // Backpressure: pipe fills after 3 accepts, stall held, then release.
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; in_data = 8'h5A; in_sh = 3'd0; in_mode = 2'd0;
    for (int cyc = 0; cyc < 100 && idx < 8; cyc++) begin
      @(negedge clk); acc = in_ready;
      if (cyc == 3) begin
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_accepts", 32'(idx), 32'd3);
      end
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(ref_shift(in_data, in_sh, in_mode));
        idx++;
        if (idx < 8) begin
          in_data = 8'(8'h5A + 8'h27 * idx); in_sh = 3'(idx); in_mode = 2'(idx);
        end else in_valid = 1'b0;
      end
      if (cyc == 5) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("bp_all_sent", 32'(idx), 32'd8);
    drain();

    // Random throttle on both sides.
    cnt = 0;
    for (int c = 0; c < 20000 && cnt < 1000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_sh     = 3'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(ref_shift(in_data, in_sh, in_mode));
        cnt++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rand_count", 32'(cnt), 32'd1000);
    drain();

    // Reset with three beats in flight.
    out_ready = 1'b0;
    send(8'h11, 3'd1, 2'd0, 9'h022);
    send(8'h81, 3'd1, 2'd1, 9'h140);
    send(8'h81, 3'd1, 2'd3, 9'h103);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out", 32'({out_carry, out_data}), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("postrst_no_stale", 32'(out_valid), 32'd0);
    end
    lat_test(8'h3C, 3'd1, 2'd0, 9'h078);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
